edge_event_fifo: RTL and testbench

//  Downstream consumer of the edge detector's pedge vector. Any cycle with a non-zero

---
 rtl/edge_event_fifo_if.sv | 29 ++
 rtl/edge_event_fifo.sv | 74 +++++++
 tb/tb_edge_event_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/edge_event_fifo_if.sv
// Edge event FIFO bus: pedge input, valid/ready event drain, occupancy and overflow status.
interface edge_event_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pedge;
  logic             ev_valid;
  logic             ev_ready;
  logic [WIDTH-1:0] ev_mask;
  logic [TS_W-1:0]  ev_time;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;

  // Producer/consumer side: drives edges, drains events, clears the sticky flag.
  modport master (
    output pedge, ev_ready, clr_ovf,
    input  ev_valid, ev_mask, ev_time, count, overflow
  );

  // FIFO side.
  modport slave (
    input  pedge, ev_ready, clr_ovf,
    output ev_valid, ev_mask, ev_time, count, overflow
  );
endinterface

// File: rtl/edge_event_fifo.sv
// Logs every non-zero pedge cycle as {timestamp, mask} into a first-word-fall-through FIFO
// with a sticky overflow flag for events dropped while full.
module edge_event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  edge_event_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [TS_W-1:0]  t;
    logic [WIDTH-1:0] m;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [TS_W-1:0] ts;
  logic            overflow_q;

  logic            valid_c;
  logic            full_c;
  logic            any_edge_c;
  logic            do_pop_c;
  logic            do_push_c;
  logic            drop_c;
  entry_t          head_c;

  // Handshake decode; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    valid_c    = (count_q != '0);
    full_c     = (count_q == CW'(DEPTH));
    any_edge_c = |bus.pedge;
    do_pop_c   = valid_c && bus.ev_ready;
    do_push_c  = any_edge_c && (!full_c || do_pop_c);
    drop_c     = any_edge_c && full_c && !do_pop_c;
    head_c     = valid_c ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      ts         <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (do_push_c) begin
        mem[wr_ptr] <= '{t: ts, m: bus.pedge};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      if (do_push_c && !do_pop_c)      count_q <= count_q + CW'(1);
      else if (do_pop_c && !do_push_c) count_q <= count_q - CW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_c)            overflow_q <= 1'b1;
      else if (bus.clr_ovf)  overflow_q <= 1'b0;
    end
  end

  assign bus.ev_valid = valid_c;
  assign bus.ev_mask  = head_c.m;
  assign bus.ev_time  = head_c.t;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_edge_event_fifo.sv
// Scoreboard bench for edge_event_fifo; a short timestamp width exercises ts wrap.
module tb_edge_event_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 4;

  typedef struct packed {
    logic [TS_W-1:0]  t;
    logic [WIDTH-1:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t            sb[$];
  logic [TS_W-1:0] ts_m;
  logic            ovf_m;

  edge_event_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  edge_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Full observable state against the model, sampled after the edge.
  task automatic check_state(input string tag);
    check_val({tag, "_count"}, 32'(bus.count), 32'(sb.size()));
    check_val({tag, "_valid"}, 32'(bus.ev_valid), 32'(sb.size() != 0));
    check_val({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_m));
    if (sb.size() != 0) begin
      check_val({tag, "_mask"}, 32'(bus.ev_mask), 32'(sb[0].m));
      check_val({tag, "_time"}, 32'(bus.ev_time), 32'(sb[0].t));
    end else begin
      check_val({tag, "_mask0"}, 32'(bus.ev_mask), 32'h0);
      check_val({tag, "_time0"}, 32'(bus.ev_time), 32'h0);
    end
  endtask

  // One clock of stimulus; expected entries pushed on drive, popped and compared on handshake.
  task automatic cyc(input logic [WIDTH-1:0] pe, input logic rdy, input logic clr, input string tag);
    exp_t e;
    logic drop;
    bus.pedge    = pe;
    bus.ev_ready = rdy;
    bus.clr_ovf  = clr;
    drop = 1'b0;
    if (sb.size() != 0 && rdy) begin
      e = sb.pop_front();
      check_val({tag, "_pop_mask"}, 32'(bus.ev_mask), 32'(e.m));
      check_val({tag, "_pop_time"}, 32'(bus.ev_time), 32'(e.t));
    end
    if (pe != '0) begin
      if (sb.size() < int'(DEPTH)) sb.push_back('{t: ts_m, m: pe});
      else drop = 1'b1;
    end
    if (drop)     ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    ts_m = ts_m + TS_W'(1);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.pedge    = 8'hFF;
    bus.ev_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    ts_m  = '0;
    ovf_m = 1'b0;
    check_state("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1 reset with pedge held high
    do_reset();

    // 2 single event after three idle clocks
    repeat (3) cyc(8'h00, 1'b0, 1'b0, "idle");
    cyc(8'h0C, 1'b0, 1'b0, "t2_push");
    check_val("t2_time3", 32'(bus.ev_time), 32'd3);
    check_val("t2_mask", 32'(bus.ev_mask), 32'h0C);
    cyc(8'h00, 1'b1, 1'b0, "t2_pop");
    check_val("t2_empty", 32'(bus.count), 32'd0);

    // 3 burst then drain; empty + push + ready does not pop
    cyc(8'h00, 1'b1, 1'b0, "t3_empty_rdy");
    cyc(8'h01, 1'b0, 1'b0, "t3_b0");
    cyc(8'h02, 1'b0, 1'b0, "t3_b1");
    cyc(8'h04, 1'b0, 1'b0, "t3_b2");
    check_val("t3_count3", 32'(bus.count), 32'd3);
    repeat (2) cyc(8'h00, 1'b0, 1'b0, "t3_stall");
    repeat (3) cyc(8'h00, 1'b1, 1'b0, "t3_drain");
    cyc(8'h10, 1'b1, 1'b0, "t3_empty_push_rdy");
    check_val("t3_no_pop", 32'(bus.count), 32'd1);
    cyc(8'h00, 1'b1, 1'b0, "t3_drain2");

    // 4 overflow, clear colliding with a drop, then a clean clear
    repeat (9) cyc(8'h45, 1'b0, 1'b0, "t4_fill");
    check_val("t4_count8", 32'(bus.count), 32'd8);
    check_val("t4_ovf", 32'(bus.overflow), 32'd1);
    cyc(8'h45, 1'b0, 1'b1, "t4_clr_drop");
    check_val("t4_set_wins", 32'(bus.overflow), 32'd1);
    cyc(8'h00, 1'b0, 1'b1, "t4_clr");
    check_val("t4_cleared", 32'(bus.overflow), 32'd0);
    cyc(8'h00, 1'b0, 1'b1, "t4_clr_idle");

    // 5 full with simultaneous push and pop
    cyc(8'h4E, 1'b1, 1'b0, "t5_pushpop");
    check_val("t5_count8", 32'(bus.count), 32'd8);
    check_val("t5_ovf0", 32'(bus.overflow), 32'd0);
    repeat (8) cyc(8'h00, 1'b1, 1'b0, "t5_drain");

    // 6 timestamp wrap
    for (int i = 0; i < 16 && ts_m != TS_W'(15); i++) cyc(8'h00, 1'b0, 1'b0, "t6_align");
    cyc(8'h21, 1'b0, 1'b0, "t6_ts15");
    cyc(8'h22, 1'b0, 1'b0, "t6_ts0");
    check_val("t6_time15", 32'(bus.ev_time), 32'd15);
    cyc(8'h00, 1'b1, 1'b0, "t6_pop");
    check_val("t6_time0", 32'(bus.ev_time), 32'd0);
    cyc(8'h00, 1'b1, 1'b0, "t6_pop2");

    // randomized traffic against the model
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 1) != 0) ? WIDTH'($urandom) : '0,
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0), "rnd");

    // mid-burst reset discards contents
    repeat (8) cyc(8'h00, 1'b1, 1'b0, "pre_drain");
    repeat (5) cyc(8'h81, 1'b0, 1'b0, "t6_fill5");
    check_val("t6_count5", 32'(bus.count), 32'd5);
    do_reset();
    cyc(8'h00, 1'b0, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
